// File: rtl/audio_pkg.sv
// Shared definitions for the audio envelope shaper: state encodings, level
// width and saturating level-step helpers.
package audio_pkg;

  localparam int ENV_LEVEL_W = 4;
  localparam logic [ENV_LEVEL_W-1:0] ENV_LEVEL_MAX = 4'd15;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

  function automatic logic [ENV_LEVEL_W-1:0] level_inc(input logic [ENV_LEVEL_W-1:0] lvl);
    return (lvl == ENV_LEVEL_MAX) ? ENV_LEVEL_MAX : lvl + 4'd1;
  endfunction

  function automatic logic [ENV_LEVEL_W-1:0] level_dec(input logic [ENV_LEVEL_W-1:0] lvl);
    return (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
  endfunction

endpackage

// File: rtl/env_pwm.sv
// 16-slot PWM gate: a free-running slot counter compared against the current
// envelope level, so level N opens the gate for N of every 16 cycles.
module env_pwm
  import audio_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ENV_LEVEL_W-1:0] level,
  output logic                   gate
);

  logic [ENV_LEVEL_W-1:0] pwm_cnt_q;
  logic [ENV_LEVEL_W-1:0] pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    gate      = (pwm_cnt_q < level);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/audio_envelope.sv
// ADSR envelope shaper: steps a 4-bit level once per TICK_DIV cycles and gates
// the incoming tone through a level-controlled PWM onto a single audio bit.
//   state   | meaning
//   IDLE    | silent, level held at 0, waiting for a note
//   ATTACK  | level rising toward 15
//   DECAY   | level falling toward SUSTAIN_LEVEL
//   SUSTAIN | level held while the note is held
//   RELEASE | note ended, level falling toward 0
module audio_envelope
  import audio_pkg::*;
#(
  parameter int TICK_DIV      = 65536,
  parameter int SUSTAIN_LEVEL = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tone_in,
  input  logic [7:0]             note_code,
  input  logic                   audio_en,
  output logic                   audio_out,
  output logic [ENV_LEVEL_W-1:0] env_level,
  output logic [2:0]             env_state
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [ENV_LEVEL_W-1:0] SUS_LVL = ENV_LEVEL_W'(SUSTAIN_LEVEL);

  logic [7:0]             note_prev_q, note_prev_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  env_state_e             state_q, state_d;
  logic [ENV_LEVEL_W-1:0] level_q, level_d;
  logic                   audio_out_q, audio_out_d;

  logic trigger;
  logic release_req;
  logic tick;
  logic gate;

  always_comb begin
    trigger     = (note_code != note_prev_q) && (note_code != 8'd0);
    release_req = (note_code == 8'd0) && (note_prev_q != 8'd0);
    tick        = (pre_q == PRE_LAST);
    note_prev_d = note_code;
    // Restarting the prescaler on a trigger makes the first step land a full
    // TICK_DIV after the note edge, independent of the previous phase.
    if (trigger || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (trigger) begin
      state_d = ENV_ATTACK;
    end else if (release_req &&
                 (state_q == ENV_ATTACK || state_q == ENV_DECAY || state_q == ENV_SUSTAIN)) begin
      state_d = ENV_RELEASE;
    end else if (tick) begin
      case (state_q)
        ENV_ATTACK: begin
          level_d = level_inc(level_q);
          if (level_d == ENV_LEVEL_MAX) begin
            state_d = ENV_DECAY;
          end
        end
        ENV_DECAY: begin
          if (level_q > SUS_LVL) begin
            level_d = level_dec(level_q);
            if (level_d == SUS_LVL) begin
              state_d = ENV_SUSTAIN;
            end
          end else begin
            state_d = ENV_SUSTAIN;
          end
        end
        ENV_RELEASE: begin
          level_d = level_dec(level_q);
          if (level_d == 4'd0) begin
            state_d = ENV_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  env_pwm u_pwm (
    .clk   (clk),
    .rst   (rst),
    .level (level_q),
    .gate  (gate)
  );

  always_comb begin
    audio_out_d = tone_in & gate & audio_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_prev_q <= '0;
      pre_q       <= '0;
      state_q     <= ENV_IDLE;
      level_q     <= '0;
      audio_out_q <= 1'b0;
    end else begin
      note_prev_q <= note_prev_d;
      pre_q       <= pre_d;
      state_q     <= state_d;
      level_q     <= level_d;
      audio_out_q <= audio_out_d;
    end
  end

  assign audio_out = audio_out_q;
  assign env_level = level_q;
  assign env_state = state_q;

endmodule

// File: tb/tb_audio_envelope.sv
// Directed bench for audio_envelope with a due-cycle scoreboard of expected
// state/level/audio values.
module tb_audio_envelope;
  import audio_pkg::*;

  localparam int TD = 4;
  localparam int SL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tone_in;
  logic [7:0] note_code;
  logic       audio_en;
  logic       audio_out;
  logic [3:0] env_level;
  logic [2:0] env_state;

  always #5 clk = ~clk;

  audio_envelope #(.TICK_DIV(TD), .SUSTAIN_LEVEL(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .note_code (note_code),
    .audio_en  (audio_en),
    .audio_out (audio_out),
    .env_level (env_level),
    .env_state (env_state)
  );

  typedef struct {
    int    due;
    int    kind;
    int    exp;
    string tag;
  } exp_t;

  exp_t q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int pwm_m  = 0;

  localparam int K_STATE = 0;
  localparam int K_LEVEL = 1;
  localparam int K_AUDIO = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    if (kind == K_STATE) return 32'(env_state);
    if (kind == K_LEVEL) return 32'(env_level);
    return 32'(audio_out);
  endfunction

  task automatic push(input int due, input int kind, input int exp, input string tag);
    exp_t e;
    int   i;
    e.due = due; e.kind = kind; e.exp = exp; e.tag = tag;
    i = 0;
    while (i < q.size() && q[i].due <= due) i++;
    q.insert(i, e);
  endtask

  task automatic check_due();
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, observe(e.kind), e.exp);
    end
  endtask

  // pwm_m tracks the DUT slot counter value visible after each edge.
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    cyc++;
    pwm_m = r ? 0 : (pwm_m + 1) % 16;
    check_due();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int trig, rel, t2, hi, lv0, n;

    rst = 1'b1; tone_in = 1'b0; audio_en = 1'b0; note_code = 8'h00;
    repeat (3) step();
    chk("rst_state", env_state, 32'(ENV_IDLE));
    chk("rst_level", env_level, 0);
    chk("rst_audio", audio_out, 0);
    rst = 1'b0;
    tone_in = 1'b1; audio_en = 1'b1;
    repeat (3) step();
    chk("idle_silent_pre", audio_out, 0);

    // Attack / decay / sustain from a note-on.
    note_code = 8'h21;
    trig = cyc + 1;
    push(trig,       K_STATE, int'(ENV_ATTACK),  "att_enter");
    push(trig,       K_LEVEL, 0,                 "att_lvl0");
    push(trig + 3,   K_LEVEL, 0,                 "att_before_step");
    push(trig + 4,   K_LEVEL, 1,                 "att_first_step");
    push(trig + 59,  K_LEVEL, 14,                "att_lvl14");
    push(trig + 59,  K_STATE, int'(ENV_ATTACK),  "att_state14");
    push(trig + 60,  K_LEVEL, 15,                "att_peak");
    push(trig + 60,  K_STATE, int'(ENV_DECAY),   "decay_enter");
    push(trig + 87,  K_LEVEL, 9,                 "decay_lvl9");
    push(trig + 88,  K_LEVEL, 8,                 "sustain_lvl");
    push(trig + 88,  K_STATE, int'(ENV_SUSTAIN), "sustain_enter");
    push(trig + 120, K_LEVEL, 8,                 "sustain_hold_lvl");
    push(trig + 120, K_STATE, int'(ENV_SUSTAIN), "sustain_hold_state");
    drain(200);

    // Random tone/enable at level 8: audio bit is one cycle behind its inputs.
    for (int i = 0; i < 32; i++) begin
      tone_in  = 1'($urandom_range(0, 1));
      audio_en = (i % 8 != 7);
      push(cyc + 1, K_AUDIO, int'(tone_in & (pwm_m < SL) & audio_en), "pwm_bit");
      step();
    end
    tone_in = 1'b1; audio_en = 1'b1;
    step();
    hi = 0;
    repeat (16) begin
      step();
      hi += int'(audio_out);
    end
    chk("duty_l8", hi, 8);

    // Release aligned to a prescaler wrap so steps fall every TD cycles.
    while ((cyc + 1 - trig) % TD != 0) step();
    note_code = 8'h00;
    rel = cyc + 1;
    push(rel,      K_STATE, int'(ENV_RELEASE), "rel_enter");
    push(rel,      K_LEVEL, 8,                 "rel_no_step");
    push(rel + 4,  K_LEVEL, 7,                 "rel_first_step");
    push(rel + 31, K_LEVEL, 1,                 "rel_lvl1");
    push(rel + 31, K_STATE, int'(ENV_RELEASE), "rel_state1");
    push(rel + 32, K_LEVEL, 0,                 "rel_done_lvl");
    push(rel + 32, K_STATE, int'(ENV_IDLE),    "rel_done_state");
    drain(60);
    step(); step();
    hi = 0;
    repeat (32) begin
      step();
      hi += int'(audio_out);
    end
    chk("idle_silent", hi, 0);

    // Retrigger coinciding with a step edge: level must hold, prescaler restarts.
    note_code = 8'h21;
    t2 = cyc + 1;
    push(t2,      K_STATE, int'(ENV_ATTACK), "att2_enter");
    push(t2,      K_LEVEL, 0,                "att2_lvl0");
    push(t2 + 24, K_LEVEL, 6,                "att2_lvl6");
    drain(40);
    step(); step(); step();
    note_code = 8'h22;
    push(t2 + 28, K_STATE, int'(ENV_ATTACK), "retrig_state");
    push(t2 + 28, K_LEVEL, 6,                "retrig_hold");
    push(t2 + 31, K_LEVEL, 6,                "retrig_wait");
    push(t2 + 32, K_LEVEL, 7,                "retrig_next_step");
    drain(10);

    // Enable drop mid-attack, chosen where the gate would otherwise be open.
    n = 0;
    while (pwm_m != 1 && n < 20) begin
      step();
      n++;
    end
    chk("en_on", audio_out, 1);
    audio_en = 1'b0;
    lv0 = int'(env_level);
    push(cyc + 1, K_AUDIO, 0, "en_off_lag");
    step();
    repeat (12) begin
      push(cyc + 1, K_AUDIO, 0, "en_off_hold");
      step();
    end
    chk("level_rising", 32'(int'(env_level) > lv0), 1);
    audio_en = 1'b1;

    // Reset in the middle of decay.
    n = 0;
    while (env_state != 3'(ENV_DECAY) && n < 200) begin
      step();
      n++;
    end
    chk("decay_reached", env_state, 32'(ENV_DECAY));
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("rst_mid_state", env_state, 32'(ENV_IDLE));
    chk("rst_mid_level", env_level, 0);
    chk("rst_mid_audio", audio_out, 0);
    rst = 1'b0;
    step();
    chk("post_rst_state", env_state, 32'(ENV_ATTACK));
    chk("post_rst_level", env_level, 0);
    push(cyc + 4, K_LEVEL, 1, "post_rst_step");
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
